// File: rtl/vx_csr_access_ctrl_pkg.sv
// Shared types for the CSR request sequencer and its read-modify-write helper.
// Combinational definitions only; no latency, no flow control.
// Backpressure: not applicable.
package vx_csr_access_ctrl_pkg;

    localparam int CSR_NUM_THREADS = 4;
    localparam int CSR_XLEN        = 32;
    localparam int CSR_NW_WIDTH    = 2;
    localparam int CSR_UUID_WIDTH  = 44;
    localparam int CSR_ADDR_WIDTH  = 12;

    typedef enum logic [1:0] {
        CSR_NOP = 2'b00,
        CSR_RW  = 2'b01,
        CSR_RS  = 2'b10,
        CSR_RC  = 2'b11
    } csr_op_e;

    // addr[11:10] == 2'b11 marks the architecturally read-only CSR space
    localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

    typedef struct packed {
        logic [CSR_UUID_WIDTH-1:0]  uuid;
        logic [CSR_NW_WIDTH-1:0]    wid;
        logic [CSR_NUM_THREADS-1:0] tmask;
        csr_op_e                    op;
        logic                       use_imm;
        logic [4:0]                 imm;
        logic                       rs1_x0;
        logic                       rd_x0;
        logic [CSR_ADDR_WIDTH-1:0]  addr;
    } csr_req_t;

endpackage

// File: rtl/vx_csr_rmw.sv
// CSR new-value and write-suppress calculator for RW/RS/RC operations.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the result with its own strobe.
module vx_csr_rmw
    import vx_csr_access_ctrl_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int CSR_ADDR_BITS = 12
) (
    input  csr_op_e                  op,
    input  logic                     use_imm,
    input  logic [4:0]               imm,
    input  logic                     rs1_x0,
    input  logic [CSR_ADDR_BITS-1:0] addr,
    input  logic [XLEN-1:0]          old_val,
    input  logic [XLEN-1:0]          src_val,
    output logic [XLEN-1:0]          new_val,
    output logic                     write_suppress
);

    logic src_is_zero;
    logic addr_is_ro;

    always_comb begin
        new_val = old_val;
        case (op)
            CSR_RW:  new_val = src_val;
            CSR_RS:  new_val = old_val | src_val;
            CSR_RC:  new_val = old_val & ~src_val;
            default: new_val = old_val;
        endcase
    end

    // Set/clear with a zero source must not write, so side-effecting CSRs stay untouched
    assign src_is_zero    = use_imm ? (imm == 5'd0) : rs1_x0;
    assign addr_is_ro     = (addr[CSR_ADDR_BITS-1 -: 2] == CSR_RO_PREFIX);
    assign write_suppress = (((op == CSR_RS) || (op == CSR_RC)) && src_is_zero)
                          || (op == CSR_NOP) || addr_is_ro;

endmodule

// File: rtl/vx_csr_access_ctrl.sv
// Request-side sequencer: accepts a CSR instruction, does read-modify-write, returns the old value.
// Latency: accept at T, CSR read/write at T+1, rsp_valid at T+2; peak one op per 2 cycles.
// Backpressure: rsp held stable until rsp_ready; req_ready only in IDLE or when the rsp drains.
module vx_csr_access_ctrl
    import vx_csr_access_ctrl_pkg::*;
#(
    parameter int NUM_THREADS   = CSR_NUM_THREADS,
    parameter int XLEN          = CSR_XLEN,
    parameter int NW_WIDTH      = CSR_NW_WIDTH,
    parameter int UUID_WIDTH    = CSR_UUID_WIDTH,
    parameter int CSR_ADDR_BITS = CSR_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [UUID_WIDTH-1:0]       req_uuid,
    input  logic [NW_WIDTH-1:0]         req_wid,
    input  logic [NUM_THREADS-1:0]      req_tmask,
    input  logic [1:0]                  req_op,
    input  logic                        req_use_imm,
    input  logic [4:0]                  req_imm,
    input  logic                        req_rs1_x0,
    input  logic                        req_rd_x0,
    input  logic [CSR_ADDR_BITS-1:0]    req_addr,
    input  logic [NUM_THREADS*XLEN-1:0] req_rs1_data,
    output logic                        csr_read_enable,
    output logic [UUID_WIDTH-1:0]       csr_read_uuid,
    output logic [NW_WIDTH-1:0]         csr_read_wid,
    output logic [CSR_ADDR_BITS-1:0]    csr_read_addr,
    input  logic [XLEN-1:0]             csr_read_data_ro,
    input  logic [XLEN-1:0]             csr_read_data_rw,
    output logic                        csr_write_enable,
    output logic [UUID_WIDTH-1:0]       csr_write_uuid,
    output logic [NW_WIDTH-1:0]         csr_write_wid,
    output logic [CSR_ADDR_BITS-1:0]    csr_write_addr,
    output logic [XLEN-1:0]             csr_write_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [UUID_WIDTH-1:0]       rsp_uuid,
    output logic [NW_WIDTH-1:0]         rsp_wid,
    output logic [NUM_THREADS-1:0]      rsp_tmask,
    output logic [NUM_THREADS*XLEN-1:0] rsp_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    state_e          state, state_n;
    csr_req_t        req_r;
    logic [XLEN-1:0] lane_src;
    logic [XLEN-1:0] src_r;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic [XLEN-1:0] rsp_val_r;
    logic            write_suppress;
    logic            accept;

    // Lowest active lane supplies rs1; an empty mask falls back to lane 0
    always_comb begin
        lane_src = req_rs1_data[XLEN-1:0];
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (req_tmask[i]) lane_src = req_rs1_data[i*XLEN +: XLEN];
        end
    end

    assign accept  = req_valid & req_ready;
    assign old_val = csr_read_data_ro | csr_read_data_rw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            req_r     <= '0;
            src_r     <= '0;
            rsp_val_r <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                req_r.uuid    <= req_uuid;
                req_r.wid     <= req_wid;
                req_r.tmask   <= req_tmask;
                req_r.op      <= csr_op_e'(req_op);
                req_r.use_imm <= req_use_imm;
                req_r.imm     <= req_imm;
                req_r.rs1_x0  <= req_rs1_x0;
                req_r.rd_x0   <= req_rd_x0;
                req_r.addr    <= req_addr;
                src_r         <= req_use_imm ? {{(XLEN-5){1'b0}}, req_imm} : lane_src;
            end
            if (state == ST_EXEC) begin
                rsp_val_r <= req_r.rd_x0 ? '0 : old_val;
            end
        end
    end

    always_comb begin
        state_n          = state;
        req_ready        = 1'b0;
        rsp_valid        = 1'b0;
        csr_read_enable  = 1'b0;
        csr_write_enable = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_n = ST_EXEC;
            end
            ST_EXEC: begin
                csr_read_enable  = ~req_r.rd_x0 | (req_r.op != CSR_RW);
                csr_write_enable = ~write_suppress;
                state_n          = ST_RSP;
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                req_ready = rsp_ready;
                if (rsp_ready) state_n = req_valid ? ST_EXEC : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    vx_csr_rmw #(
        .XLEN          (XLEN),
        .CSR_ADDR_BITS (CSR_ADDR_BITS)
    ) u_rmw (
        .op             (req_r.op),
        .use_imm        (req_r.use_imm),
        .imm            (req_r.imm),
        .rs1_x0         (req_r.rs1_x0),
        .addr           (req_r.addr),
        .old_val        (old_val),
        .src_val        (src_r),
        .new_val        (new_val),
        .write_suppress (write_suppress)
    );

    assign csr_read_uuid  = req_r.uuid;
    assign csr_read_wid   = req_r.wid;
    assign csr_read_addr  = req_r.addr;
    assign csr_write_uuid = req_r.uuid;
    assign csr_write_wid  = req_r.wid;
    assign csr_write_addr = req_r.addr;
    assign csr_write_data = new_val;
    assign rsp_uuid       = req_r.uuid;
    assign rsp_wid        = req_r.wid;
    assign rsp_tmask      = req_r.tmask;
    assign rsp_data       = {NUM_THREADS{rsp_val_r}};

endmodule

// File: tb/tb_vx_csr_access_ctrl.sv
// Directed bench for vx_csr_access_ctrl: drives on the falling edge, samples on the falling edge.
module tb_vx_csr_access_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [43:0]  req_uuid = '0;
    logic [1:0]   req_wid = 2'd1;
    logic [3:0]   req_tmask = '0;
    logic [1:0]   req_op = '0;
    logic         req_use_imm = 1'b0;
    logic [4:0]   req_imm = '0;
    logic         req_rs1_x0 = 1'b0;
    logic         req_rd_x0 = 1'b0;
    logic [11:0]  req_addr = '0;
    logic [127:0] req_rs1_data = '0;
    logic         csr_read_enable;
    logic [43:0]  csr_read_uuid;
    logic [1:0]   csr_read_wid;
    logic [11:0]  csr_read_addr;
    logic [31:0]  csr_read_data_ro = '0;
    logic [31:0]  csr_read_data_rw = '0;
    logic         csr_write_enable;
    logic [43:0]  csr_write_uuid;
    logic [1:0]   csr_write_wid;
    logic [11:0]  csr_write_addr;
    logic [31:0]  csr_write_data;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [43:0]  rsp_uuid;
    logic [1:0]   rsp_wid;
    logic [3:0]   rsp_tmask;
    logic [127:0] rsp_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vx_csr_access_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_uuid(req_uuid), .req_wid(req_wid),
        .req_tmask(req_tmask), .req_op(req_op), .req_use_imm(req_use_imm), .req_imm(req_imm),
        .req_rs1_x0(req_rs1_x0), .req_rd_x0(req_rd_x0), .req_addr(req_addr), .req_rs1_data(req_rs1_data),
        .csr_read_enable(csr_read_enable), .csr_read_uuid(csr_read_uuid), .csr_read_wid(csr_read_wid),
        .csr_read_addr(csr_read_addr), .csr_read_data_ro(csr_read_data_ro), .csr_read_data_rw(csr_read_data_rw),
        .csr_write_enable(csr_write_enable), .csr_write_uuid(csr_write_uuid), .csr_write_wid(csr_write_wid),
        .csr_write_addr(csr_write_addr), .csr_write_data(csr_write_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_uuid(rsp_uuid), .rsp_wid(rsp_wid),
        .rsp_tmask(rsp_tmask), .rsp_data(rsp_data)
    );

    // Called on a falling edge; returns on the falling edge where the DUT sits in EXEC.
    task automatic drive_req(input logic [1:0] op, input logic use_imm, input logic [4:0] imm,
                             input logic rs1_x0, input logic rd_x0, input logic [11:0] addr,
                             input logic [3:0] tmask, input logic [127:0] rs1, input logic [43:0] uuid);
        int n = 0;
        req_op = op; req_use_imm = use_imm; req_imm = imm; req_rs1_x0 = rs1_x0;
        req_rd_x0 = rd_x0; req_addr = addr; req_tmask = tmask; req_rs1_data = rs1;
        req_uuid = uuid; req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 16) $display("FAIL accept_timeout: req_ready got %b required 1", req_ready);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_data !== 128'h0) $display("FAIL reset_rsp_data: got %h required 0", rsp_data); else n_pass++;
        n_checks++; if (csr_read_enable !== 1'b0) $display("FAIL reset_read_en: got %b required 0", csr_read_enable); else n_pass++;
        n_checks++; if (csr_write_enable !== 1'b0) $display("FAIL reset_write_en: got %b required 0", csr_write_enable); else n_pass++;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b required 1", req_ready); else n_pass++;
    endtask

    task automatic test_rw;
        csr_read_data_rw = 32'h12345678; csr_read_data_ro = 32'h0;
        drive_req(2'b01, 1'b0, 5'd0, 1'b0, 1'b0, 12'h340, 4'b1111,
                  {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF}, 44'h1);
        n_checks++; if (csr_read_enable !== 1'b1) $display("FAIL rw_read_en: got %b required 1", csr_read_enable); else n_pass++;
        n_checks++; if (csr_write_enable !== 1'b1) $display("FAIL rw_write_en: got %b required 1", csr_write_enable); else n_pass++;
        n_checks++; if (csr_write_data !== 32'hDEADBEEF) $display("FAIL rw_write_data: got %h required deadbeef", csr_write_data); else n_pass++;
        n_checks++; if (csr_write_addr !== 12'h340) $display("FAIL rw_write_addr: got %h required 340", csr_write_addr); else n_pass++;
        n_checks++; if (csr_read_addr !== 12'h340) $display("FAIL rw_read_addr: got %h required 340", csr_read_addr); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rw_rsp_early: got %b required 0", rsp_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL rw_rsp_valid: got %b required 1", rsp_valid); else n_pass++;
        n_checks++; if (rsp_data !== {4{32'h12345678}}) $display("FAIL rw_rsp_data: got %h required 4x12345678", rsp_data); else n_pass++;
        n_checks++; if (rsp_uuid !== 44'h1) $display("FAIL rw_rsp_uuid: got %h required 1", rsp_uuid); else n_pass++;
        n_checks++; if (rsp_tmask !== 4'b1111) $display("FAIL rw_rsp_tmask: got %b required 1111", rsp_tmask); else n_pass++;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rw_rsp_drop: got %b required 0", rsp_valid); else n_pass++;
        // rd=x0 skips the read; empty mask takes lane 0
        drive_req(2'b01, 1'b0, 5'd0, 1'b0, 1'b1, 12'h340, 4'b0000,
                  {32'h33333333, 32'h22222222, 32'h11111111, 32'hCAFEF00D}, 44'h2);
        n_checks++; if (csr_read_enable !== 1'b0) $display("FAIL rwx0_read_en: got %b required 0", csr_read_enable); else n_pass++;
        n_checks++; if (csr_write_data !== 32'hCAFEF00D) $display("FAIL rwx0_write_data: got %h required cafef00d", csr_write_data); else n_pass++;
        @(negedge clk);
        n_checks++; if (rsp_data !== 128'h0) $display("FAIL rwx0_rsp_data: got %h required 0", rsp_data); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_rs_x0;
        csr_read_data_rw = 32'h12345678;
        drive_req(2'b10, 1'b0, 5'd0, 1'b1, 1'b0, 12'h340, 4'b1111, {4{32'hFFFFFFFF}}, 44'h3);
        n_checks++; if (csr_read_enable !== 1'b1) $display("FAIL rs_x0_read_en: got %b required 1", csr_read_enable); else n_pass++;
        n_checks++; if (csr_write_enable !== 1'b0) $display("FAIL rs_x0_write_en: got %b required 0", csr_write_enable); else n_pass++;
        @(negedge clk);
        n_checks++; if (rsp_data !== {4{32'h12345678}}) $display("FAIL rs_x0_rsp_data: got %h required 4x12345678", rsp_data); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_rc_lane;
        csr_read_data_rw = 32'h000000FF;
        drive_req(2'b11, 1'b0, 5'd0, 1'b0, 1'b0, 12'h340, 4'b0100,
                  {32'h0000FFFF, 32'h0000000F, 32'hFFFFFFFF, 32'hFFFFFFFF}, 44'h4);
        n_checks++; if (csr_write_enable !== 1'b1) $display("FAIL rc_write_en: got %b required 1", csr_write_enable); else n_pass++;
        n_checks++; if (csr_write_data !== 32'h000000F0) $display("FAIL rc_write_data: got %h required 000000f0", csr_write_data); else n_pass++;
        @(negedge clk);
        n_checks++; if (rsp_data !== {4{32'h000000FF}}) $display("FAIL rc_rsp_data: got %h required 4x000000ff", rsp_data); else n_pass++;
        n_checks++; if (rsp_tmask !== 4'b0100) $display("FAIL rc_rsp_tmask: got %b required 0100", rsp_tmask); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_rsi_imm;
        csr_read_data_rw = 32'h0;
        drive_req(2'b10, 1'b1, 5'd0, 1'b0, 1'b0, 12'h001, 4'b0001, {4{32'hFFFFFFFF}}, 44'h5);
        n_checks++; if (csr_write_enable !== 1'b0) $display("FAIL rsi0_write_en: got %b required 0", csr_write_enable); else n_pass++;
        n_checks++; if (csr_read_enable !== 1'b1) $display("FAIL rsi0_read_en: got %b required 1", csr_read_enable); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        drive_req(2'b10, 1'b1, 5'd5, 1'b1, 1'b0, 12'h001, 4'b0001, {4{32'hFFFFFFFF}}, 44'h6);
        n_checks++; if (csr_write_enable !== 1'b1) $display("FAIL rsi5_write_en: got %b required 1", csr_write_enable); else n_pass++;
        n_checks++; if (csr_write_data !== 32'h00000005) $display("FAIL rsi5_write_data: got %h required 00000005", csr_write_data); else n_pass++;
        @(negedge clk);
        n_checks++; if (rsp_data !== 128'h0) $display("FAIL rsi5_rsp_data: got %h required 0", rsp_data); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_read_only;
        csr_read_data_ro = 32'hABCD0001; csr_read_data_rw = 32'h0;
        drive_req(2'b01, 1'b0, 5'd0, 1'b0, 1'b0, 12'hF14, 4'b0001, {4{32'h55555555}}, 44'h7);
        n_checks++; if (csr_read_enable !== 1'b1) $display("FAIL ro_read_en: got %b required 1", csr_read_enable); else n_pass++;
        n_checks++; if (csr_write_enable !== 1'b0) $display("FAIL ro_write_en: got %b required 0", csr_write_enable); else n_pass++;
        @(negedge clk);
        n_checks++; if (rsp_data !== {4{32'hABCD0001}}) $display("FAIL ro_rsp_data: got %h required 4xabcd0001", rsp_data); else n_pass++;
        @(negedge clk);
        csr_read_data_ro = 32'h0;
    endtask

    task automatic test_back_to_back;
        csr_read_data_rw = 32'hAAAA0000;
        rsp_ready = 1'b0;
        drive_req(2'b01, 1'b0, 5'd0, 1'b0, 1'b0, 12'h340, 4'b0001, {96'h0, 32'h00000001}, 44'hA);
        req_op = 2'b10; req_use_imm = 1'b0; req_rs1_x0 = 1'b0; req_rd_x0 = 1'b0;
        req_addr = 12'h341; req_tmask = 4'b0001; req_rs1_data = {96'h0, 32'h00000002};
        req_uuid = 44'hB; req_valid = 1'b1;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL b2b_exec_ready: got %b required 0", req_ready); else n_pass++;
        n_checks++; if (csr_write_data !== 32'h00000001) $display("FAIL b2b_a_write_data: got %h required 00000001", csr_write_data); else n_pass++;
        repeat (3) begin
            @(negedge clk);
            n_checks++; if (rsp_valid !== 1'b1) $display("FAIL b2b_hold_valid: got %b required 1", rsp_valid); else n_pass++;
            n_checks++; if (req_ready !== 1'b0) $display("FAIL b2b_hold_ready: got %b required 0", req_ready); else n_pass++;
            n_checks++; if ({csr_read_enable, csr_write_enable} !== 2'b00) $display("FAIL b2b_hold_strobes: got %b required 00", {csr_read_enable, csr_write_enable}); else n_pass++;
            n_checks++; if (rsp_uuid !== 44'hA) $display("FAIL b2b_hold_uuid: got %h required a", rsp_uuid); else n_pass++;
        end
        @(negedge clk);
        csr_read_data_rw = 32'hBBBB0000;
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL b2b_drain_ready: got %b required 1", req_ready); else n_pass++;
        n_checks++; if (rsp_data !== {4{32'hAAAA0000}}) $display("FAIL b2b_a_rsp_data: got %h required 4xaaaa0000", rsp_data); else n_pass++;
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL b2b_exec_valid: got %b required 0", rsp_valid); else n_pass++;
        n_checks++; if (csr_write_data !== 32'hBBBB0002) $display("FAIL b2b_b_write_data: got %h required bbbb0002", csr_write_data); else n_pass++;
        n_checks++; if (csr_write_addr !== 12'h341) $display("FAIL b2b_b_write_addr: got %h required 341", csr_write_addr); else n_pass++;
        @(negedge clk);
        n_checks++; if (rsp_uuid !== 44'hB) $display("FAIL b2b_b_rsp_uuid: got %h required b", rsp_uuid); else n_pass++;
        n_checks++; if (rsp_data !== {4{32'hBBBB0000}}) $display("FAIL b2b_b_rsp_data: got %h required 4xbbbb0000", rsp_data); else n_pass++;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL b2b_no_double: got %b required 0", rsp_valid); else n_pass++;
    endtask

    task automatic test_reset_in_exec;
        csr_read_data_rw = 32'h77777777;
        drive_req(2'b01, 1'b0, 5'd0, 1'b0, 1'b0, 12'h340, 4'b0001, {96'h0, 32'h1}, 44'hC);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_exec_rsp_valid: got %b required 0", rsp_valid); else n_pass++;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_exec_req_ready: got %b required 1", req_ready); else n_pass++;
        n_checks++; if ({csr_read_enable, csr_write_enable} !== 2'b00) $display("FAIL rst_exec_strobes: got %b required 00", {csr_read_enable, csr_write_enable}); else n_pass++;
        n_checks++; if (rsp_data !== 128'h0) $display("FAIL rst_exec_rsp_data: got %h required 0", rsp_data); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_exec_after: got %b required 0", rsp_valid); else n_pass++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_rw();
        test_rs_x0();
        test_rc_lane();
        test_rsi_imm();
        test_read_only();
        test_back_to_back();
        test_reset_in_exec();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vx_csr_access_ctrl.md
Name: vx_csr_access_ctrl

Overview:
Request-side sequencer for the core's CSR storage. It accepts CSR instructions (CSRRW/CSRRS/CSRRC and their immediate forms) from the SFU dispatch path over a valid/ready handshake. It drives the CSR storage's combinational read port and single-cycle write port, performs the read-modify-write, and returns the old CSR value, broadcast to all active threads, over a valid/ready response handshake.

Parameters:
NUM_THREADS, 4, threads per warp
XLEN, 32, data width
NW_WIDTH, 2, warp-id width
UUID_WIDTH, 44, instruction trace id width
CSR_ADDR_BITS, 12, CSR address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_uuid  in  UUID_WIDTH  trace id
req_wid  in  NW_WIDTH  warp id
req_tmask  in  NUM_THREADS  active-thread mask
req_op  in  2  01=RW, 10=RS, 11=RC; 00 reserved, treated as no-op read
req_use_imm  in  1  source is zero-extended req_imm instead of rs1
req_imm  in  5  uimm field
req_rs1_x0  in  1  rs1 index is x0
req_rd_x0  in  1  rd index is x0
req_addr  in  CSR_ADDR_BITS  CSR address
req_rs1_data  in  NUM_THREADS*XLEN  per-thread rs1 values
csr_read_enable  out  1  read strobe
csr_read_uuid / csr_read_wid / csr_read_addr  out  UUID_WIDTH / NW_WIDTH / CSR_ADDR_BITS  read qualifiers
csr_read_data_ro  in  XLEN  read-only data (combinational)
csr_read_data_rw  in  XLEN  read-write data (combinational)
csr_write_enable  out  1  write strobe
csr_write_uuid / csr_write_wid / csr_write_addr  out  UUID_WIDTH / NW_WIDTH / CSR_ADDR_BITS  write qualifiers
csr_write_data  out  XLEN  value to write
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_uuid / rsp_wid / rsp_tmask  out  UUID_WIDTH / NW_WIDTH / NUM_THREADS  echoed from request
rsp_data  out  NUM_THREADS*XLEN  old CSR value on every lane

Behaviour:
- FSM states IDLE, EXEC, RSP. Reset forces IDLE, clears the request register, and drops any in-flight operation. Reset values: rsp_valid=0, rsp_data=0, csr_read_enable=0, csr_write_enable=0, req_ready=1 (first cycle after reset).
- IDLE: req_ready=1. On req_valid, latch all req_* fields and go to EXEC.
- EXEC (exactly one cycle):
  - csr_read_enable = ~rd_x0 | (op!=RW).
  - Sample old = read_data_ro | read_data_rw.
  - Source: src = use_imm ? XLEN'(imm) : rs1 of the lowest-indexed set tmask bit. If tmask==0, use lane 0.
  - New value: RW→src; RS→old|src; RC→old&~src.
  - write_suppress = (op∈{RS,RC} & (use_imm ? imm==0 : rs1_x0)) | op==00 | addr[11:10]==2'b11.
  - csr_write_enable = ~write_suppress. Writes are single-cycle pulses.
  - Capture rsp_data = rd_x0 ? 0 : old on all lanes. Go to RSP.
- RSP: rsp_valid=1, held stable until rsp_ready.
  - On rsp_ready: if req_valid is also high, latch the new request and go to EXEC (req_ready=rsp_ready in RSP). Otherwise go to IDLE.
- Latency and throughput: accept at T, read/write at T+1, rsp_valid at T+2. Back-to-back peak throughput is one op per 2 cycles.
- Read and write of the same CSR in EXEC: the read returns the pre-write value, because storage updates at the clock edge.
- The qualifier outputs (uuid/wid/addr) always reflect the latched request. Strobes are asserted only in EXEC.
- rsp_ready low in RSP: no new accept, no CSR strobes.

Decomposition:
- Shared package: csr_op enum (RW/RS/RC), CSR read-only range constant (addr[11:10]==2'b11), and a request struct typedef (uuid, wid, tmask, op, imm, flags, addr).
- One natural sub-module: vx_csr_rmw, a combinational new-value/suppress calculator, reused by an FPU-CSR path later.

Test Plan:
- CSRRW addr=0x340, rs1 lane0=0xDEADBEEF, mscratch=0x12345678, tmask=4'b1111 → at T+1 write 0xDEADBEEF; rsp_data=0x12345678 on all 4 lanes at T+2.
- CSRRS addr=0x340, rs1_x0=1 → write_enable=0, read_enable=1, rsp returns the current value.
- CSRRC, tmask=4'b0100, lane2=0x0000000F, old=0xFF → write 0xF0.
- CSRRSI imm=0 vs imm=5 on 0x001, old=0x0 → no write vs write 0x5.
- CSRR of 0xF14 (read-only) via CSRRW rd_x0=0 → write suppressed; read performed.
- Back-to-back: hold rsp_ready=0 for 3 cycles, then 1 with a new req_valid → no double accept, second rsp 2 cycles later. Assert reset in EXEC → no rsp, IDLE next cycle.
